// File: rtl/jk_seq_pkg.sv
// Shared types for the JK counter sequencer: mode encoding and FSM states.
// Imported by jk_count_seq; no ports.
package jk_seq_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_TGL  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DOWN = 2'b10;
   localparam logic [1:0] M_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
// Ports: clk, reset (active-low, sync), j, k -> q. jk: 00 hold, 01 clr, 10 set, 11 tgl.
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= 1'b0;
      end else begin
         unique case ({j, k})
            2'b00: q <= q;
            2'b01: q <= 1'b0;
            2'b10: q <= 1'b1;
            2'b11: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_count_seq.sv
// Sequencer driving a bank of JK cells: load, count up/down, toggle or hold
// for a captured number of steps. Ports: clk, reset (active-low, sync), start,
// mode[1:0], steps, load, load_val -> q, busy, done, sat.
// Optional saturation feature enabled by defining JK_COUNT_SEQ_SAT_EN.
module jk_count_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] steps,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             sat
);

   import jk_seq_pkg::*;

   state_t           state;
   state_t           state_nx;
   mode_t            mode_r;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   logic [WIDTH-1:0] t;
   logic             up_c;
   logic             dn_c;
   logic             go;
   logic             in_idle;
   logic             in_run;

   assign in_idle = (state == ST_IDLE);
   assign in_run  = (state == ST_RUN);
   // load has priority over start in IDLE; start is simply dropped
   assign go      = in_idle && start && !load;

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (go) state_nx = (steps == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (cnt == WIDTH'(1)) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_RUN) || (state == ST_DONE);
      done = (state == ST_DONE);
   end

   // cnt holds steps still to apply, including the current RUN cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         mode_r <= MODE_HOLD;
      end else if (go) begin
         cnt    <= steps;
         mode_r <= mode_t'(mode);
      end else if (in_run) begin
         cnt    <= cnt - WIDTH'(1);
      end
   end

   // Prefix ANDs: bit i toggles when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      up_t = '0;
      dn_t = '0;
      up_c = 1'b1;
      dn_c = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         up_t[i] = up_c;
         dn_t[i] = dn_c;
         up_c    = up_c & q[i];
         dn_c    = dn_c & ~q[i];
      end
   end

`ifdef JK_COUNT_SEQ_SAT_EN
   logic sat_hit;
   assign sat_hit = in_run &&
                    ((mode_r == MODE_UP   && (&q)) ||
                     (mode_r == MODE_DOWN && !(|q)));

   always_ff @(posedge clk) begin
      if (!reset)                      sat <= 1'b0;
      else if (in_idle && load)        sat <= 1'b0;
      else if (go)                     sat <= 1'b0;
      else if (sat_hit)                sat <= 1'b1;
   end
`else
   assign sat = 1'b0;
`endif

   always_comb begin
      t = '0;
      unique case (mode_r)
         MODE_HOLD: t = '0;
         MODE_UP:   t = up_t;
         MODE_DOWN: t = dn_t;
         MODE_TGL:  t = '1;
      endcase
`ifdef JK_COUNT_SEQ_SAT_EN
      if (sat_hit) t = '0;
`endif
   end

   always_comb begin
      j = '0;
      k = '0;
      if (in_idle && load) begin
         j = load_val;
         k = ~load_val;
      end else if (in_run) begin
         j = t;
         k = t;
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[gi]),
         .k     (k[gi]),
         .q     (q[gi])
      );
   end

endmodule

// File: tb/tb_jk_count_seq.sv
// Self-checking bench for jk_count_seq: directed scenarios then random
// stimulus compared every cycle against a behavioural model.
module tb_jk_count_seq;

   localparam int W    = 4;
   localparam int FULL = (1 << W) - 1;
`ifdef JK_COUNT_SEQ_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   mode;
   logic [W-1:0] steps;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         busy;
   logic         done;
   logic         sat;

   always #5 clk = ~clk;

   jk_count_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .steps    (steps),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .sat      (sat)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // model: phase 0 idle, 1 run, 2 done
   int m_q    = 0;
   int m_ph   = 0;
   int m_rem  = 0;
   int m_mode = 0;
   int m_sat  = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_step();
      if (!reset) begin
         m_q = 0; m_ph = 0; m_rem = 0; m_mode = 0; m_sat = 0;
      end else begin
         case (m_ph)
            0: begin
               if (load) begin
                  m_q = int'(load_val);
                  m_sat = 0;
               end else if (start) begin
                  m_sat  = 0;
                  m_mode = int'(mode);
                  m_rem  = int'(steps);
                  m_ph   = (m_rem == 0) ? 2 : 1;
               end
            end
            1: begin
               case (m_mode)
                  1: if (SAT && m_q == FULL) m_sat = 1;
                     else m_q = (m_q + 1) % (FULL + 1);
                  2: if (SAT && m_q == 0) m_sat = 1;
                     else m_q = (m_q + FULL) % (FULL + 1);
                  3: m_q = FULL - m_q;
                  default: ;
               endcase
               m_rem--;
               if (m_rem == 0) m_ph = 2;
            end
            default: m_ph = 0;
         endcase
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("q",    32'(q),    32'(m_q));
      check("busy", 32'(busy), 32'(m_ph != 0));
      check("done", 32'(done), 32'(m_ph == 2));
      check("sat",  32'(sat),  32'(m_sat));
   endtask

   task automatic drive(input logic r, input logic s, input logic l,
                        input logic [1:0] md, input logic [W-1:0] st,
                        input logic [W-1:0] lv);
      reset = r; start = s; load = l; mode = md; steps = st; load_val = lv;
   endtask

   logic [W-1:0] up_exp [5];

   initial begin
      up_exp[0] = 4'b1110; up_exp[1] = 4'b1111; up_exp[2] = 4'b0000;
      up_exp[3] = 4'b0001; up_exp[4] = 4'b0010;

      // reset for two cycles
      drive(0, 0, 0, 2'b00, '0, '0);
      tick(); tick();
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();
      check("rst_q", 32'(q), 0);
      check("rst_busy", 32'(busy), 0);

      // load 1101 then count up 5
      drive(1, 0, 1, 2'b00, '0, 4'b1101);
      tick();
      check("load_q", 32'(q), 32'hd);
      drive(1, 1, 0, 2'b01, 4'd5, '0);
      tick();
      drive(1, 0, 0, 2'b00, '0, '0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("up_seq", 32'(q), 32'(up_exp[i]));
      end
      check("up_done6", 32'(done), 1);
      tick();
      check("up_busy7", 32'(busy), 0);

      // down from 0, 2 steps
      drive(1, 0, 1, 2'b00, '0, 4'b0000);
      tick();
      drive(1, 1, 0, 2'b10, 4'd2, '0);
      tick();
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();
      tick();
      check("dn_q", 32'(q), SAT ? 32'h0 : 32'he);
      check("dn_sat", 32'(sat), 32'(SAT));
      check("dn_done3", 32'(done), 1);
      tick();

      // zero steps
      drive(1, 1, 0, 2'b01, 4'd0, '0);
      tick();
      check("z_done", 32'(done), 1);
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();

      // load and start together
      drive(1, 1, 1, 2'b01, 4'd3, 4'b0101);
      tick();
      check("ls_q", 32'(q), 32'h5);
      check("ls_busy", 32'(busy), 0);
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();

      // toggle with reset abort and ignored start
      drive(1, 0, 1, 2'b00, '0, 4'b1010);
      tick();
      drive(1, 1, 0, 2'b11, 4'd3, '0);
      tick();
      drive(1, 1, 0, 2'b01, 4'd7, '0);
      tick();
      check("tg_q1", 32'(q), 32'h5);
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();
      check("tg_q2", 32'(q), 32'ha);
      drive(0, 0, 0, 2'b00, '0, '0);
      tick();
      check("ab_q", 32'(q), 0);
      check("ab_busy", 32'(busy), 0);
      drive(1, 0, 0, 2'b00, '0, '0);
      tick();
      check("ab_done", 32'(done), 0);

      // random
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0),
               2'($urandom),
               W'($urandom_range(0, 9)),
               W'($urandom));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/jk_count_seq.md
JK_COUNT_SEQ -- requirements
Module: jk_count_seq

Interface
REQ-001 Parameter: WIDTH, default 4, number of JK cells in the counter bank (2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge only.
REQ-004 start  input  1  request to run a sequence; honoured only in IDLE.
REQ-005 mode  input  2  00 hold, 01 count up, 10 count down, 11 toggle all bits.
REQ-006 steps  input  WIDTH  number of steps to apply; captured with start.
REQ-007 load  input  1  parallel load request; honoured only in IDLE.
REQ-008 load_val  input  WIDTH  value applied by load.
REQ-009 q  output  WIDTH  bank state, bit i is cell i Q.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse at sequence completion.
REQ-012 sat  output  1  sticky saturation flag; behaviour set by REQ-028.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE plus load=1: drive j=load_val[i] and k=~load_val[i] on every cell, so q=load_val on the next edge; state stays IDLE.
REQ-015 IDLE, start=1, load=0: capture mode and steps; go to RUN, or go directly to DONE when steps=0, with q unchanged.
REQ-016 load and start both high in IDLE: load wins; start is dropped and SHALL NOT be queued.
REQ-017 start or load asserted in RUN or DONE SHALL be ignored.
REQ-018 RUN applies one step per cycle, for exactly the captured steps count; q advances on each RUN edge.
REQ-019 Up step: j_i=k_i=AND(q[i-1:0]), with bit 0 always toggling.
REQ-020 Down step: j_i=k_i=AND(~q[i-1:0]), with bit 0 always toggling.
REQ-021 Toggle step: j=k=1 on all cells. Hold step: j=k=0 on all cells, so q is unchanged while cycles still elapse.
REQ-022 Without saturation, up wraps from all-ones to 0 and down wraps from 0 to all-ones.
REQ-023 After the last step, RUN goes to DONE; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-024 Latency: with N>0 steps, done is high in the (N+1)th cycle after the start edge. With steps=0, done is high in the 1st cycle after the start edge.
REQ-025 In IDLE with no load, all cells SHALL be driven j=k=0, so q holds.

Reset
REQ-026 reset=0 at an edge SHALL force q=0, busy=0, done=0, sat=0 and state IDLE; this takes priority over all other inputs.
REQ-027 Reset during RUN SHALL abort the sequence with no done pulse and SHALL discard the captured mode and steps.

Configuration
REQ-028 Macro JK_COUNT_SEQ_SAT_EN, when defined:
  - an up step with q all-ones, or a down step with q=0, SHALL drive j=k=0 (q holds);
  - sat SHALL be set, and cleared at the next accepted start or load;
  - remaining steps still consume cycles.
  When the macro is undefined, wrap per REQ-022 applies and sat is tied 0.

Structure
REQ-029 Shared package jk_seq_pkg SHALL hold the mode encoding typedef, the FSM state typedef and the mode constants.
REQ-030 Each bit SHALL be one instance of sub-module jk_cell:
  - a JK cell with the same clk and active-low synchronous reset;
  - j/k function 00 hold, 01 clear, 10 set, 11 toggle.
  jk_count_seq contains only the FSM, the step counter and the j/k decode.

Verification
REQ-031 WIDTH=4, reset low for 2 cycles, then high -> q=0, busy=0, done=0, sat=0.
REQ-032 load=1 with load_val=1101 in IDLE -> q=1101 next cycle. Then start, mode=01, steps=5 -> q sequence 1110, 1111, 0000, 0001, 0010; done high in cycle 6; busy low in cycle 7.
REQ-033 q=0000, start with mode=10 and steps=2 -> q 1111, 1110 without the macro. With JK_COUNT_SEQ_SAT_EN -> q stays 0000, sat=1, done still in cycle 3.
REQ-034 start with steps=0 -> done in the next cycle and q unchanged. load and start together -> only the load takes effect and busy stays 0.
REQ-035 start with mode=11 and steps=3 from q=1010, then reset asserted after the 2nd step -> q=0, no done pulse, state IDLE. A start pulse during RUN is ignored.
